// File: rtl/supercar_scanner.sv
// Bouncing / rotating LED pattern register with a built-in step prescaler.
// The pattern sweeps end to end with an optional dwell at each end, or rotates, or holds.
module supercar_scanner #(
    parameter int N_BIT   = 8,
    parameter int PRESC_W = 16,
    parameter int DWELL   = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               sin,
    input  logic [1:0]         mode,
    input  logic [PRESC_W-1:0] div,
    output logic [N_BIT-1:0]   pout,
    output logic               dir,
    output logic               step
);

    // state       | meaning
    // ST_UP       | shifting toward MSB
    // ST_DWELL_UP | parked at the MSB end, next move is down
    // ST_DOWN     | shifting toward LSB
    // ST_DWELL_DN | parked at the LSB end, next move is up
    typedef enum logic [1:0] {
        ST_UP       = 2'd0,
        ST_DWELL_UP = 2'd1,
        ST_DOWN     = 2'd2,
        ST_DWELL_DN = 2'd3
    } state_t;

    localparam logic [7:0] DWELL_C = 8'(DWELL);

    state_t               state;
    state_t               state_nxt;
    logic [7:0]           dc;
    logic [7:0]           dc_nxt;
    logic [PRESC_W-1:0]   pc;
    logic                 tick;
    logic [N_BIT-1:0]     pout_nxt;
    logic [N_BIT-1:0]     shift_up;
    logic [N_BIT-1:0]     shift_dn;

    // >= rather than == so that lowering div below the running count ticks at once
    assign tick = en && (pc >= div);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= '0;
        end else if (en) begin
            pc <= tick ? '0 : pc + 1'b1;
        end
    end

    always_comb begin
        shift_up  = {pout[N_BIT-2:0], sin};
        shift_dn  = {sin, pout[N_BIT-1:1]};
        state_nxt = state;
        pout_nxt  = pout;
        dc_nxt    = dc;
        if (tick) begin
            case (mode)
                2'b00: begin
                    case (state)
                        ST_UP: begin
                            if (!pout[N_BIT-1]) begin
                                pout_nxt = shift_up;
                            end else if (DWELL == 0) begin
                                pout_nxt  = shift_dn;
                                state_nxt = ST_DOWN;
                            end else begin
                                dc_nxt    = 8'd1;
                                state_nxt = ST_DWELL_UP;
                            end
                        end
                        ST_DWELL_UP: begin
                            if (dc == DWELL_C) begin
                                pout_nxt  = shift_dn;
                                state_nxt = ST_DOWN;
                            end else begin
                                dc_nxt = dc + 8'd1;
                            end
                        end
                        ST_DOWN: begin
                            if (!pout[0]) begin
                                pout_nxt = shift_dn;
                            end else if (DWELL == 0) begin
                                pout_nxt  = shift_up;
                                state_nxt = ST_UP;
                            end else begin
                                dc_nxt    = 8'd1;
                                state_nxt = ST_DWELL_DN;
                            end
                        end
                        default: begin
                            if (dc == DWELL_C) begin
                                pout_nxt  = shift_up;
                                state_nxt = ST_UP;
                            end else begin
                                dc_nxt = dc + 8'd1;
                            end
                        end
                    endcase
                end
                2'b01: begin
                    pout_nxt  = {pout[N_BIT-2:0], pout[N_BIT-1] | sin};
                    state_nxt = ST_UP;
                    dc_nxt    = '0;
                end
                2'b10: begin
                    pout_nxt  = {pout[0] | sin, pout[N_BIT-1:1]};
                    state_nxt = ST_DOWN;
                    dc_nxt    = '0;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_UP;
            pout  <= '0;
            dc    <= '0;
            step  <= 1'b0;
        end else begin
            state <= state_nxt;
            pout  <= pout_nxt;
            dc    <= dc_nxt;
            step  <= tick;
        end
    end

    // dir reports the direction of the next movement, so it flips on entering a dwell
    assign dir = (state == ST_DOWN) || (state == ST_DWELL_UP);

endmodule
